// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, queues {pc, op} pairs from the ROM and hands them to decode.
// Optional FETCH_STATS_EN macro builds saturating push/redirect counters; otherwise stat outputs read zero.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter int         DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_pc,
  input  logic [15:0] imem_op,
  output logic        dec_valid,
  output logic [15:0] dec_op,
  output logic [7:0]  dec_pc,
  input  logic        dec_ready,
  input  logic        redir_valid,
  input  logic [7:0]  redir_pc,
  output logic [15:0] stat_fetch,
  output logic [15:0] stat_flush
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    fpc_q, fpc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;
  logic [7:0]    pc_mem_q [DEPTH];
  logic [15:0]   op_mem_q [DEPTH];
  logic          pop_s, push_s;

  assign pop_s  = valid_q & dec_ready;
  assign push_s = !redir_valid & ((count_q < DEPTH_C) | pop_s);

  // Next-state for fetch PC and queue pointers; redirect overrides everything.
  always_comb begin
    fpc_d   = fpc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redir_valid) begin
      fpc_d   = redir_pc;
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_s) begin
        fpc_d  = fpc_q + 8'd1;
        tail_d = tail_q + PW'(1);
      end else begin
        fpc_d  = fpc_q;
      end
      if (pop_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q   <= RESET_PC;
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      valid_q <= 1'b0;
    end else begin
      fpc_q   <= fpc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= (count_d != {CW{1'b0}});
    end
  end

  // Queue storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[tail_q] <= fpc_q;
      op_mem_q[tail_q] <= imem_op;
    end
  end

  assign imem_pc   = fpc_q;
  assign dec_valid = valid_q;
  assign dec_op    = valid_q ? op_mem_q[head_q] : 16'd0;
  assign dec_pc    = valid_q ? pc_mem_q[head_q] : 8'd0;

`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetch_q, stat_fetch_d;
  logic [15:0] stat_flush_q, stat_flush_d;

  // Saturating event counters.
  always_comb begin
    stat_fetch_d = stat_fetch_q;
    stat_flush_d = stat_flush_q;
    if (push_s && (stat_fetch_q != 16'hFFFF)) begin
      stat_fetch_d = stat_fetch_q + 16'd1;
    end else begin
      stat_fetch_d = stat_fetch_q;
    end
    if (redir_valid && (stat_flush_q != 16'hFFFF)) begin
      stat_flush_d = stat_flush_q + 16'd1;
    end else begin
      stat_flush_d = stat_flush_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetch_q <= 16'd0;
      stat_flush_q <= 16'd0;
    end else begin
      stat_fetch_q <= stat_fetch_d;
      stat_flush_q <= stat_flush_d;
    end
  end

  assign stat_fetch = stat_fetch_q;
  assign stat_flush = stat_flush_q;
`else
  assign stat_fetch = 16'd0;
  assign stat_flush = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational ROM model (DEPTH=2, RESET_PC=0).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_pc;
  logic [15:0] imem_op;
  logic        dec_valid;
  logic [15:0] dec_op;
  logic [7:0]  dec_pc;
  logic        dec_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [7:0]  redir_pc = 8'd0;
  logic [15:0] stat_fetch;
  logic [15:0] stat_flush;

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] rom_f(input logic [7:0] pc);
    return {~pc, pc ^ 8'h3C};
  endfunction

  assign imem_op = rom_f(imem_pc);

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(8'd0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_pc(imem_pc), .imem_op(imem_op),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .stat_fetch(stat_fetch), .stat_flush(stat_flush)
  );

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redir_valid = 1'b0;
    dec_ready = ready;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dec_ready = 1'b0;
    @(negedge clk);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", dec_valid); end
    checks++; if (dec_op !== 16'd0) begin errors++; $display("FAIL reset_op got=%h exp=0000", dec_op); end
    checks++; if (dec_pc !== 8'd0) begin errors++; $display("FAIL reset_pc got=%h exp=00", dec_pc); end
    checks++; if (imem_pc !== 8'd0) begin errors++; $display("FAIL reset_imem_pc got=%h exp=00", imem_pc); end
    checks++; if (stat_fetch !== 16'd0 || stat_flush !== 16'd0) begin
      errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_fetch, stat_flush); end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 8'(k) || dec_op !== rom_f(8'(k))) begin
        errors++; $display("FAIL stream[%0d] got v=%0b pc=%h op=%h exp v=1 pc=%h op=%h",
                           k, dec_valid, dec_pc, dec_op, 8'(k), rom_f(8'(k)));
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0] exp_pc;
    do_reset(1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (imem_pc !== 8'd2 || dec_pc !== 8'd0 || dec_valid !== 1'b1) begin
          errors++; $display("FAIL stall[%0d] got imem_pc=%h dec_pc=%h v=%0b exp 02/00/1",
                             k, imem_pc, dec_pc, dec_valid);
        end
      end
    end
    exp_pc = 8'd0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_op !== rom_f(exp_pc)) begin
        errors++; $display("FAIL release[%0d] got v=%0b pc=%h exp v=1 pc=%h", k, dec_valid, dec_pc, exp_pc);
      end
      dec_ready = 1'b1;
      @(negedge clk);
      exp_pc = exp_pc + 8'd1;
    end
  endtask

  task automatic test_redirect_full;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    checks++; if (imem_pc !== 8'd2) begin errors++; $display("FAIL full_pre got imem_pc=%h exp 02", imem_pc); end
    redir_valid = 1'b1;
    redir_pc = 8'd20;
    dec_ready = 1'b1;
    @(negedge clk);
    redir_valid = 1'b0;
    checks++;
    if (dec_valid !== 1'b0 || imem_pc !== 8'd20 || dec_op !== 16'd0 || dec_pc !== 8'd0) begin
      errors++; $display("FAIL redir_n1 got v=%0b imem_pc=%h op=%h pc=%h exp 0/14/0000/00",
                         dec_valid, imem_pc, dec_op, dec_pc);
    end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'd20 || dec_op !== rom_f(8'd20)) begin
      errors++; $display("FAIL redir_n2 got v=%0b pc=%h exp v=1 pc=14", dec_valid, dec_pc); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'd21) begin
      errors++; $display("FAIL redir_n3 got v=%0b pc=%h exp v=1 pc=15", dec_valid, dec_pc); end
  endtask

  task automatic test_redirect_pop;
    do_reset(1'b1);
    repeat (8) @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'd7) begin
      errors++; $display("FAIL pop_head got v=%0b pc=%h exp v=1 pc=07", dec_valid, dec_pc); end
    redir_valid = 1'b1;
    redir_pc = 8'd26;
    @(negedge clk);
    redir_valid = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin
      errors++; $display("FAIL pop_bubble got v=%0b pc=%h exp v=0", dec_valid, dec_pc); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'd26 || dec_op !== rom_f(8'd26)) begin
      errors++; $display("FAIL pop_target got v=%0b pc=%h exp v=1 pc=1a", dec_valid, dec_pc); end
    @(negedge clk);
    checks++; if (dec_pc !== 8'd27) begin
      errors++; $display("FAIL pop_next got pc=%h exp 1b", dec_pc); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
    dec_ready = 1'b1;
    redir_valid = 1'b1;
    redir_pc = 8'hFE;
    @(negedge clk);
    redir_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_seq[k] || dec_op !== rom_f(exp_seq[k])) begin
        errors++; $display("FAIL wrap[%0d] got v=%0b pc=%h exp v=1 pc=%h", k, dec_valid, dec_pc, exp_seq[k]);
      end
    end
  endtask

  task automatic test_stats;
    logic [15:0] exp_fetch, exp_flush;
`ifdef FETCH_STATS_EN
    exp_fetch = 16'd10;
    exp_flush = 16'd2;
`else
    exp_fetch = 16'd0;
    exp_flush = 16'd0;
`endif
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    redir_valid = 1'b1;
    redir_pc = 8'd40;
    repeat (2) @(negedge clk);
    redir_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (stat_fetch !== exp_fetch) begin
      errors++; $display("FAIL stat_fetch got=%0d exp=%0d", stat_fetch, exp_fetch); end
    checks++; if (stat_flush !== exp_flush) begin
      errors++; $display("FAIL stat_flush got=%0d exp=%0d", stat_flush, exp_flush); end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (dec_valid !== 1'b0 || imem_pc !== 8'd0 || dec_pc !== 8'd0 || dec_op !== 16'd0) begin
      errors++; $display("FAIL midrst got v=%0b imem_pc=%h pc=%h op=%h exp 0/00/00/0000",
                         dec_valid, imem_pc, dec_pc, dec_op);
    end
    @(negedge clk);
    rst = 1'b0;
    dec_ready = 1'b1;
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'd0) begin
      errors++; $display("FAIL midrst_restart got v=%0b pc=%h exp v=1 pc=00", dec_valid, dec_pc); end
    @(negedge clk);
    checks++; if (dec_pc !== 8'd1) begin
      errors++; $display("FAIL midrst_next got pc=%h exp 01", dec_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_stats();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
